// File: rtl/uart_pkg.sv
// Shared definitions for the memory-to-UART transmitter.
//   state_t    : transmitter FSM states
//   cnt_width  : counter width for a modulus n (never less than 1 bit)
//   DATA_BITS / STOP_BITS / FRAME_BITS : 8N1 frame geometry
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  // Width of a counter that must hold the values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button input conditioning: two-flop synchroniser followed by a
// previous-value register and a falling-edge detector.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset; all flops return to released (1)
//   btn  : active-low asynchronous button
//   fall : one-cycle pulse when the synchronised button goes 1 -> 0
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Registered inputs only, so the pulse is clean for a full cycle.
  assign fall = prev & ~sync2;

endmodule

// File: rtl/uart_mem_tx.sv
// Transmit-only UART that sends MEMORY_LENGTH bytes of a parallel message
// as back-to-back 8N1 frames after a button press.
// Parameters:
//   DELAY_FRAMES  : clocks per UART bit (>= 2)
//   MEMORY_LENGTH : number of bytes in data (>= 1)
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   data    : message; byte k is data[8k+7:8k], byte 0 sent first
//   uart_tx : registered serial output, idles high
//   btn1    : active-low asynchronous start button
module uart_mem_tx
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES  = 8,
  parameter int MEMORY_LENGTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MEMORY_LENGTH*8-1:0] data,
  output logic                       uart_tx,
  input  logic                       btn1
);

  localparam int CW = cnt_width(DELAY_FRAMES);
  localparam int BW = cnt_width(MEMORY_LENGTH);

  localparam logic [CW-1:0] CNT_LAST      = CW'(DELAY_FRAMES - 1);
  localparam logic [BW-1:0] BYTE_LAST     = BW'(MEMORY_LENGTH - 1);
  localparam logic [2:0]    DATA_BIT_LAST = 3'(DATA_BITS - 1);

  logic start_evt;

  btn_sync_edge u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn1),
    .fall (start_evt)
  );

  state_t                     state, state_next;
  logic [CW-1:0]              clk_cnt, clk_cnt_next;
  logic [2:0]                 bit_idx, bit_idx_next;
  logic [BW-1:0]              byte_idx, byte_idx_next;
  logic [MEMORY_LENGTH*8-1:0] data_q, data_q_next;
  logic [7:0]                 cur_byte;
  logic                       tx_next;
  logic                       bit_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      data_q   <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_next;
      clk_cnt  <= clk_cnt_next;
      bit_idx  <= bit_idx_next;
      byte_idx <= byte_idx_next;
      data_q   <= data_q_next;
      uart_tx  <= tx_next;
    end
  end

  assign bit_done = (clk_cnt == CNT_LAST);

  always_comb begin
    state_next    = state;
    clk_cnt_next  = clk_cnt;
    bit_idx_next  = bit_idx;
    byte_idx_next = byte_idx;
    data_q_next   = data_q;

    case (state)
      IDLE: begin
        clk_cnt_next  = '0;
        bit_idx_next  = '0;
        byte_idx_next = '0;
        // The start event is only honoured here; presses while busy and the
        // cycle of the STOP->IDLE transition fall into other branches.
        if (start_evt) begin
          state_next  = START;
          data_q_next = data;
        end
      end
      START: begin
        if (bit_done) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          clk_cnt_next = '0;
          if (bit_idx == DATA_BIT_LAST) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          clk_cnt_next = '0;
          if (byte_idx == BYTE_LAST) begin
            byte_idx_next = '0;
            state_next    = IDLE;
          end else begin
            byte_idx_next = byte_idx + BW'(1);
            state_next    = START;
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The line level is computed from the next state so that uart_tx can be
  // a plain register and still change on the same edge as the FSM.
  always_comb begin
    cur_byte = data_q_next[8*byte_idx_next +: 8];
    tx_next  = 1'b1;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = cur_byte[bit_idx_next];
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_mem_tx.sv
// Self-checking bench for uart_mem_tx (DELAY_FRAMES=8, MEMORY_LENGTH=2).
// The driver pushes each expected frame (start cycle + 10 line levels) into
// exp_q when it presses the button; a monitor decodes frames off uart_tx and
// compares them against the queue.
module tb_uart_mem_tx;

  localparam int D = 8;
  localparam int M = 2;
  localparam int W = 42;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn1 = 1'b1;
  logic [15:0] data = 16'h0000;
  logic        uart_tx;
  logic [31:0] cyc = 32'd0;

  int checks = 0;
  int fails  = 0;

  logic [W-1:0] exp_q[$];

  // Clock and cycle counter; cyc equals the number of rising edges seen.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  uart_mem_tx #(
    .DELAY_FRAMES  (D),
    .MEMORY_LENGTH (M)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .uart_tx (uart_tx),
    .btn1    (btn1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic press(output logic [31:0] c);
    @(negedge clk);
    btn1 = 1'b0;
    c = cyc;
  endtask

  task automatic release_btn(input int n);
    repeat (n) @(negedge clk);
    btn1 = 1'b1;
  endtask

  // Frame word: bit 0 = start level, bits 1..8 = data LSB first, bit 9 = stop.
  task automatic push_frame(input logic [31:0] s, input logic [7:0] b);
    exp_q.push_back({s, 1'b1, b, 1'b0});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  initial begin : monitor
    logic         mon_prev;
    logic [9:0]   frame;
    logic [31:0]  sc;
    logic         ab;
    logic         gl;
    logic [W-1:0] e;
    mon_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev = 1'b1;
      end else if (mon_prev && !uart_tx) begin
        sc    = cyc;
        ab    = 1'b0;
        gl    = 1'b0;
        frame = '0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < D; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (rst) begin
              ab = 1'b1;
              break;
            end
            if (s == 0) frame[b] = uart_tx;
            else if (uart_tx !== frame[b]) gl = 1'b1;
          end
          if (ab) break;
        end
        if (!ab) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_frame: got frame %03h at cycle %0d, required no frame", frame, sc);
          end else begin
            e = exp_q.pop_front();
            check("frame_bits", 32'(frame), 32'(e[9:0]));
            check("frame_start_cycle", sc, e[41:10]);
            check("bit_hold", 32'(gl), 32'd0);
          end
        end
        mon_prev = rst ? 1'b1 : uart_tx;
      end else begin
        mon_prev = uart_tx;
      end
    end
  end

  // Driver
  initial begin : driver
    logic [31:0] c;

    // Reset idle
    repeat (3) begin
      @(negedge clk);
      check("reset_idle", 32'(uart_tx), 32'd1);
    end
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      check("post_reset_idle", 32'(uart_tx), 32'd1);
    end

    // Basic frame pair, 0xAA 0xAA
    data = 16'hAAAA;
    press(c);
    push_frame(c + 32'd3, 8'hAA);
    push_frame(c + 32'd83, 8'hAA);
    release_btn(4);
    wait_cycles(200);
    check("drain_basic", 32'(exp_q.size()), 32'd0);

    // Byte order, with data changed mid-transfer
    data = 16'h0041;
    press(c);
    push_frame(c + 32'd3, 8'h41);
    push_frame(c + 32'd83, 8'h00);
    release_btn(4);
    wait_cycles(20);
    data = 16'hFFFF;
    wait_cycles(200);
    check("drain_byte_order", 32'(exp_q.size()), 32'd0);

    // Held button: one transfer only, then release and press again
    data = 16'h5A3C;
    press(c);
    push_frame(c + 32'd3, 8'h3C);
    push_frame(c + 32'd83, 8'h5A);
    release_btn(400);
    wait_cycles(20);
    check("drain_held", 32'(exp_q.size()), 32'd0);
    press(c);
    push_frame(c + 32'd3, 8'h3C);
    push_frame(c + 32'd83, 8'h5A);
    release_btn(4);
    wait_cycles(200);
    check("drain_repress", 32'(exp_q.size()), 32'd0);

    // Second press at clock 50 of a transfer is ignored
    data = 16'hC381;
    press(c);
    push_frame(c + 32'd3, 8'h81);
    push_frame(c + 32'd83, 8'hC3);
    release_btn(4);
    wait_cycles(49);
    btn1 = 1'b0;
    release_btn(4);
    wait_cycles(200);
    check("drain_busy_press", 32'(exp_q.size()), 32'd0);

    // Reset during DATA of byte 0 (byte 0 = 0x00 so the line is low there)
    data = 16'h5500;
    press(c);
    release_btn(4);
    wait_cycles(27);
    check("line_low_in_data", 32'(uart_tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("tx_after_reset", 32'(uart_tx), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(200);
    check("no_frame_after_abort", 32'(exp_q.size()), 32'd0);
    press(c);
    push_frame(c + 32'd3, 8'h00);
    push_frame(c + 32'd83, 8'h55);
    release_btn(4);
    wait_cycles(200);
    check("drain_restart", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
